sink_mem_ctrl: RTL and testbench
================================

Name: sink_mem_ctrl

Overview:
- Controller for the single-port 8-bit capture RAM (f_mem class: address, data, wren in; q out) on the receive side.
- Arms on start_sink, discards a fixed preamble of valid bytes, writes the frame to addresses 0..END_ADDRESS, then flags full.
- Shares the same RAM port with a readback requester that dumps the captured frame.
- Sits between the receive datapath and the RAM; it is the only driver of the RAM port.

Parameters:
- ADDR_W, 8, RAM address width.
- END_ADDRESS, 10, last address written; a frame is END_ADDRESS+1 bytes. Legal range 0..2^ADDR_W-1.
- SKIP_COUNT, 2, valid bytes discarded after arming, before the first write. 0 means no skip.
- READ_LATENCY, 1, RAM cycles from address sampled to q valid (1..3).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_sink  in  1  one-cycle pulse; arm or re-arm capture.
- wr_valid  in  1  wr_data is valid this cycle.
- wr_data  in  8  received byte.
- rd_start  in  1  one-cycle pulse; request a dump of the captured frame.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_data  out  8  RAM write data (registered).
- mem_wren  out  1  RAM write enable (registered).
- mem_q  in  8  RAM read data.
- rd_data  out  8  dumped byte (registered).
- rd_valid  out  1  rd_data valid.
- wr_count  out  ADDR_W+1  bytes written in the current or last frame.
- busy  out  1  state is SKIP, WRITE or DUMP.
- full  out  1  level; frame complete.
- done  out  1  one-cycle pulse on the final frame write.
- rd_done  out  1  one-cycle pulse when a dump finishes.

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0. wr_ptr, skip_cnt, pending flag and read pipeline cleared. RAM contents are not touched.
- States: IDLE, SKIP, WRITE, FULL, DUMP.
- IDLE:
  - start_sink -> SKIP, or WRITE directly if SKIP_COUNT=0. wr_ptr=0, wr_count=0.
  - Else rd_start -> DUMP.
  - start_sink and rd_start in the same cycle: start_sink wins; rd_start is dropped.
- SKIP: each wr_valid increments skip_cnt and the byte is not written. On the SKIP_COUNT-th valid byte -> WRITE.
- WRITE: on a wr_valid edge, register mem_addr=wr_ptr, mem_data=wr_data, mem_wren=1; then wr_ptr++ and wr_count++. mem_wren is 0 in every cycle with no such write.
  - Write latency is 1 cycle: the byte is on the RAM port in the cycle after wr_valid.
  - When the write targets END_ADDRESS: pulse done with mem_wren, set full, go to FULL. wr_ptr never wraps.
- FULL: wr_valid is ignored. start_sink re-arms (clears full, wr_count=0, goes to SKIP/WRITE). rd_start -> DUMP.
- DUMP:
  - Issue one read per cycle, addresses 0..wr_count-1, with mem_wren=0.
  - rd_valid/rd_data for an address appear READ_LATENCY+1 cycles after that address is on mem_addr, consecutively and in address order.
  - After the last byte: pulse rd_done in the cycle after its rd_valid, then return to the entry state (IDLE or FULL).
  - wr_count=0: pulse rd_done on the next cycle with no rd_valid.
- start_sink during SKIP/WRITE: restart the capture (wr_ptr=0, skip_cnt=0, wr_count=0, full=0, enter SKIP).
- start_sink during DUMP: latch a pending flag. After the dump completes, go to SKIP/WRITE instead of the entry state. rd_done still pulses.
- rd_start during SKIP/WRITE/DUMP: ignored.
- busy=1 exactly in SKIP, WRITE and DUMP.

Optional Feature:
- Macro: SINK_MEM_CTRL_OVF_CNT_EN.
- Defined: adds output ovf_count (16 bits), counting wr_valid cycles seen in FULL. It saturates at 0xFFFF, clears on reset and on start_sink, and is readable at any time.
- Undefined: the port and counter are absent. Dropped bytes are silently discarded.

Test Plan:
- Reset: reset low mid-WRITE at wr_ptr=5 -> all outputs 0 immediately, state IDLE. After release, rd_start dumps nothing and rd_done pulses the next cycle.
- Basic capture: start_sink, then bytes 0xA0..0xAC on consecutive wr_valid -> 0xA0, 0xA1 not written; 0xA2..0xAC written to addresses 0..10; done pulses once with the write to address 10; full=1; wr_count=11.
- Overflow: in FULL send 3 more bytes -> no mem_wren. With SINK_MEM_CTRL_OVF_CNT_EN, ovf_count=3.
- Dump: after the capture above, rd_start -> rd_valid for 11 consecutive cycles with rd_data 0xA2..0xAC. The first rd_valid is READ_LATENCY+1 cycles after mem_addr=0. rd_done pulses; state returns to FULL.
- Gapped input: wr_valid asserted every third cycle -> writes only in the cycle after each wr_valid, addresses contiguous, mem_wren=0 between.
- Collisions: start_sink and rd_start together in IDLE -> capture starts, no dump. start_sink mid-dump -> dump completes, rd_done pulses, then capture re-arms with wr_count=0.

Source files
------------

// File: rtl/sink_mem_ctrl.sv
// Purpose : receive-side controller for the single-port 8-bit capture RAM. It drops a preamble,
//           captures one frame into addresses 0..END_ADDRESS, and dumps the frame back on request.
// Latency : a write reaches the RAM port 1 cycle after wr_valid. A dumped byte leaves on rd_data
//           READ_LATENCY+1 cycles after its address is on mem_addr.
// Backpressure: none. wr_valid bytes that arrive in FULL, IDLE or DUMP are dropped.
//
// Ports:
//   clk, reset (async, active-low)    clock and reset
//   start_sink, wr_valid, wr_data     arm/re-arm pulse and the receive byte stream
//   rd_start                          request a dump of the captured frame
//   mem_addr/mem_data/mem_wren, mem_q RAM port; this block is its only driver
//   rd_data/rd_valid, rd_done         dump stream and its end-of-dump pulse
//   wr_count, busy, full, done        capture status
// Optional: define SINK_MEM_CTRL_OVF_CNT_EN to add ovf_count, a saturating count of the
//   wr_valid cycles seen in FULL. It clears on reset and on start_sink.
module sink_mem_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int END_ADDRESS  = 10,
    parameter int SKIP_COUNT   = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_sink,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    input  logic              rd_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wren,
    input  logic [7:0]        mem_q,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   wr_count,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic              rd_done
`ifdef SINK_MEM_CTRL_OVF_CNT_EN
    ,
    output logic [15:0]       ovf_count
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SKIP  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_FULL  = 3'd3;
    localparam logic [2:0] S_DUMP  = 3'd4;

    // The width is sized so that SKIP_COUNT=0 still gives a legal 1-bit counter.
    localparam int SKIP_W = $clog2(SKIP_COUNT + 2);
    localparam logic [SKIP_W-1:0] SKIP_LAST = (SKIP_COUNT == 0) ? '0 : SKIP_W'(SKIP_COUNT - 1);
    localparam logic [ADDR_W-1:0] END_A     = ADDR_W'(END_ADDRESS);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [2:0]        ARM_STATE = (SKIP_COUNT == 0) ? S_WRITE : S_SKIP;

    logic [2:0]              state;
    logic [ADDR_W-1:0]       wr_ptr;
    logic [SKIP_W-1:0]       skip_cnt;
    logic [ADDR_W:0]         rd_ptr;
    logic                    pend;
    logic                    issue_vld;
    logic                    issue_last;
    logic [READ_LATENCY-1:0] vld_sr;
    logic [READ_LATENCY-1:0] last_sr;
    logic                    rd_last;
    logic                    dump_end;
    logic                    arm;

    // The dump ends when the registered last byte is on rd_data. The read pipeline is empty
    // at that point, so re-arming here cannot corrupt a read that is still in flight.
    assign dump_end = (state == S_DUMP) && rd_valid && rd_last;

    // A start_sink that arrives during a dump is held in pend and acted on at dump_end.
    assign arm = ((state != S_DUMP) && start_sink) ||
                 (dump_end && (pend || start_sink));

    assign busy = (state == S_SKIP) || (state == S_WRITE) || (state == S_DUMP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            skip_cnt   <= '0;
            rd_ptr     <= '0;
            pend       <= 1'b0;
            issue_vld  <= 1'b0;
            issue_last <= 1'b0;
            vld_sr     <= '0;
            last_sr    <= '0;
            rd_last    <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_wren   <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            wr_count   <= '0;
            full       <= 1'b0;
            done       <= 1'b0;
            rd_done    <= 1'b0;
        end else begin
            mem_wren   <= 1'b0;
            done       <= 1'b0;
            issue_vld  <= 1'b0;
            issue_last <= 1'b0;
            rd_done    <= dump_end;

            // Read return path. Each issue flag travels READ_LATENCY stages so that it lines
            // up with mem_q. The byte is then registered onto rd_data.
            vld_sr[0]  <= issue_vld;
            last_sr[0] <= issue_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
            rd_valid <= vld_sr[READ_LATENCY-1];
            rd_last  <= last_sr[READ_LATENCY-1];
            if (vld_sr[READ_LATENCY-1]) begin
                rd_data <= mem_q;
            end

            if (arm) begin
                state    <= ARM_STATE;
                wr_ptr   <= '0;
                skip_cnt <= '0;
                wr_count <= '0;
                full     <= 1'b0;
                pend     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_FULL: begin
                        if (rd_start) begin
                            // An empty frame has nothing to read, so finish the dump at once.
                            if (wr_count == '0) begin
                                rd_done <= 1'b1;
                            end else begin
                                state  <= S_DUMP;
                                rd_ptr <= '0;
                            end
                        end
                    end
                    S_SKIP: begin
                        if (wr_valid) begin
                            if (skip_cnt == SKIP_LAST) begin
                                state <= S_WRITE;
                            end else begin
                                skip_cnt <= skip_cnt + SKIP_W'(1);
                            end
                        end
                    end
                    S_WRITE: begin
                        if (wr_valid) begin
                            mem_addr <= wr_ptr;
                            mem_data <= wr_data;
                            mem_wren <= 1'b1;
                            wr_count <= wr_count + CNT_ONE;
                            if (wr_ptr == END_A) begin
                                done  <= 1'b1;
                                full  <= 1'b1;
                                state <= S_FULL;
                            end else begin
                                wr_ptr <= wr_ptr + ADDR_W'(1);
                            end
                        end
                    end
                    S_DUMP: begin
                        if (start_sink) begin
                            pend <= 1'b1;
                        end
                        if (rd_ptr != wr_count) begin
                            mem_addr   <= rd_ptr[ADDR_W-1:0];
                            issue_vld  <= 1'b1;
                            issue_last <= ((rd_ptr + CNT_ONE) == wr_count);
                            rd_ptr     <= rd_ptr + CNT_ONE;
                        end
                        // Return to the state the dump was entered from. full tells which one.
                        if (dump_end) begin
                            state <= full ? S_FULL : S_IDLE;
                            pend  <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef SINK_MEM_CTRL_OVF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_count <= '0;
        end else if (start_sink) begin
            ovf_count <= '0;
        end else if ((state == S_FULL) && wr_valid && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sink_mem_ctrl.sv
module tb_sink_mem_ctrl;
    localparam int AW   = 8;
    localparam int ENDA = 10;
    localparam int SKIP = 2;
    localparam int RL   = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_sink;
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          rd_start;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_wren;
    logic [7:0]    mem_q;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [AW:0]   wr_count;
    logic          busy;
    logic          full;
    logic          done;
    logic          rd_done;
`ifdef SINK_MEM_CTRL_OVF_CNT_EN
    logic [15:0]   ovf_count;
`endif

    sink_mem_ctrl #(.ADDR_W(AW), .END_ADDRESS(ENDA), .SKIP_COUNT(SKIP), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(rst_n), .start_sink(start_sink), .wr_valid(wr_valid),
        .wr_data(wr_data), .rd_start(rd_start), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_count(wr_count), .busy(busy), .full(full), .done(done), .rd_done(rd_done)
`ifdef SINK_MEM_CTRL_OVF_CNT_EN
        , .ovf_count(ovf_count)
`endif
    );

    always #5 clk = ~clk;

    // Single-port RAM with a read latency of one cycle.
    logic [7:0] ram [256];
    logic [7:0] q_reg = 8'd0;
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        q_reg <= ram[mem_addr];
    end
    assign mem_q = q_reg;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
        int         cyc;
    } wr_exp_t;

    wr_exp_t    wq[$];
    logic [7:0] rq[$];
    logic [7:0] cap [256];

    // Reference model of the capture. It is updated when a byte is driven.
    int m_skip, m_ptr, m_ovf;
    bit m_act, m_full;

    task automatic model_reset();
        m_act = 0; m_full = 0; m_skip = 0; m_ptr = 0; m_ovf = 0;
        wq.delete();
    endtask

    task automatic model_arm();
        m_act = 1; m_full = 0; m_skip = 0; m_ptr = 0; m_ovf = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        wr_exp_t e;
        if (!m_act) return;
        if (m_full) begin
            m_ovf++;
        end else if (m_skip < SKIP) begin
            m_skip++;
        end else begin
            e.addr = 8'(m_ptr); e.data = b; e.last = (m_ptr == ENDA); e.cyc = cyc;
            wq.push_back(e);
            cap[m_ptr] = b;
            m_ptr++;
            if (m_ptr == ENDA + 1) m_full = 1;
        end
    endtask

    // Monitor state for the dump.
    int n_done = 0, n_rd_done = 0, rdv_n = 0, last_rdv = 0, t0 = -1;
    bit dumping = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wren) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", {31'd0, mem_wren}, 32'd0);
                end else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
                    check("wr_data", {24'd0, mem_data}, {24'd0, e.data});
                    check("wr_done", {31'd0, done}, {31'd0, e.last});
                    check("wr_latency", cyc, e.cyc + 1);
                end
            end else if (done) begin
                check("done_without_wr", {31'd0, done}, 32'd0);
            end
            if (dumping && t0 < 0 && busy && !mem_wren && mem_addr == '0) t0 = cyc;
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    check("rd_unexpected", {31'd0, rd_valid}, 32'd0);
                end else begin
                    check("rd_data", {24'd0, rd_data}, {24'd0, rq.pop_front()});
                end
                if (rdv_n > 0) check("rd_gap", cyc, last_rdv + 1);
                else if (t0 >= 0) check("rd_latency", cyc - t0, RL + 1);
                rdv_n++;
                last_rdv = cyc;
            end
            if (rd_done) begin
                n_rd_done++;
                if (rdv_n > 0) check("rd_done_timing", cyc, last_rdv + 1);
            end
            if (done) n_done++;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b);
        wr_valid = 1'b1; wr_data = b;
        model_byte(b);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start_sink = 1'b1;
        model_arm();
        step();
        start_sink = 1'b0;
    endtask

    task automatic load_dump();
        for (int i = 0; i < m_ptr; i++) rq.push_back(cap[i]);
        rdv_n = 0; t0 = -1; dumping = 1;
    endtask

    task automatic wait_rd_done(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (rd_done) got = 1;
        end
        check("rd_done_seen", {31'd0, got}, 32'd1);
        dumping = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
        check({tag, "_mem_data"}, {24'd0, mem_data}, 32'd0);
        check({tag, "_mem_wren"}, {31'd0, mem_wren}, 32'd0);
        check({tag, "_rd_data"},  {24'd0, rd_data},  32'd0);
        check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        check({tag, "_wr_count"}, {23'd0, wr_count}, 32'd0);
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_full"},     {31'd0, full},     32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_rd_done"},  {31'd0, rd_done},  32'd0);
    endtask

    initial begin
        int nrd0;
        rst_n = 1'b0; start_sink = 1'b0; wr_valid = 1'b0; wr_data = 8'd0; rd_start = 1'b0;
        model_reset();
        #3;
        check_zero("por");
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset applied mid-WRITE with wr_ptr at 5.
        pulse_start();
        check("arm_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 7; i++) send(8'h30 + 8'(i));
        step();
        check("pre_reset_wr_count", {23'd0, wr_count}, 32'd5);
        check("pre_reset_wq_empty", wq.size(), 0);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        model_reset();
        step();
        rst_n = 1'b1;
        step();
        rd_start = 1'b1; step(); rd_start = 1'b0;
        check("empty_dump_rd_done", {31'd0, rd_done}, 32'd1);
        check("empty_dump_rd_valid", {31'd0, rd_valid}, 32'd0);
        step();
        check("empty_dump_rd_done_clr", {31'd0, rd_done}, 32'd0);
        check("empty_dump_idle", {31'd0, busy}, 32'd0);

        // Basic capture: 0xA0 and 0xA1 are skipped, 0xA2..0xAC go to addresses 0..10.
        n_done = 0;
        pulse_start();
        for (int i = 0; i < 13; i++) send(8'hA0 + 8'(i));
        step(); step();
        check("cap_full", {31'd0, full}, 32'd1);
        check("cap_wr_count", {23'd0, wr_count}, 32'd11);
        check("cap_done_count", n_done, 1);
        check("cap_idle", {31'd0, busy}, 32'd0);
        check("cap_wq_empty", wq.size(), 0);

        // Overflow: bytes sent in FULL must not be written.
        for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i));
        step();
        check("ovf_full", {31'd0, full}, 32'd1);
        check("ovf_wr_count", {23'd0, wr_count}, 32'd11);
`ifdef SINK_MEM_CTRL_OVF_CNT_EN
        check("ovf_count", {16'd0, ovf_count}, 32'd3);
`endif

        // Dump the captured frame.
        load_dump();
        rd_start = 1'b1; step(); rd_start = 1'b0;
        wait_rd_done(40);
        check("dump_rq_empty", rq.size(), 0);
        check("dump_rd_count", rdv_n, 11);
        step();
        check("dump_ret_full", {31'd0, full}, 32'd1);
        check("dump_ret_not_busy", {31'd0, busy}, 32'd0);

        // Gapped input: wr_valid every third cycle.
        n_done = 0;
        pulse_start();
        check("rearm_wr_count", {23'd0, wr_count}, 32'd0);
        check("rearm_full", {31'd0, full}, 32'd0);
        check("rearm_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 13; i++) begin
            send(8'h50 + 8'(i));
            step(); step();
        end
        check("gap_full", {31'd0, full}, 32'd1);
        check("gap_wr_count", {23'd0, wr_count}, 32'd11);
        check("gap_done_count", n_done, 1);
        check("gap_wq_empty", wq.size(), 0);
`ifdef SINK_MEM_CTRL_OVF_CNT_EN
        check("gap_ovf_cleared", {16'd0, ovf_count}, 32'd0);
`endif

        // Collision in IDLE: start_sink wins and the rd_start is dropped.
        rst_n = 1'b0; model_reset(); step(); rst_n = 1'b1; step();
        nrd0 = n_rd_done;
        start_sink = 1'b1; rd_start = 1'b1;
        model_arm();
        step();
        start_sink = 1'b0; rd_start = 1'b0;
        check("coll_busy", {31'd0, busy}, 32'd1);
        check("coll_no_rd_done", {31'd0, rd_done}, 32'd0);
        step();
        check("coll_no_rd_valid", {31'd0, rd_valid}, 32'd0);
        for (int i = 0; i < 13; i++) send(8'h10 + 8'(i));
        step(); step();
        check("coll_full", {31'd0, full}, 32'd1);
        check("coll_no_dump", n_rd_done, nrd0);

        // start_sink during a dump: the dump completes, then the capture re-arms.
        load_dump();
        rd_start = 1'b1; step(); rd_start = 1'b0;
        step(); step(); step();
        start_sink = 1'b1; step(); start_sink = 1'b0;
        wait_rd_done(40);
        model_arm();
        check("pend_rq_empty", rq.size(), 0);
        check("pend_rd_count", rdv_n, 11);
        check("pend_rearm_busy", {31'd0, busy}, 32'd1);
        check("pend_rearm_wr_count", {23'd0, wr_count}, 32'd0);
        check("pend_rearm_full", {31'd0, full}, 32'd0);
        step();
        send(8'h55); send(8'h66); send(8'h77);
        step();
        check("pend_wr_count", {23'd0, wr_count}, 32'd1);
        check("pend_wq_empty", wq.size(), 0);
        check("pend_busy", {31'd0, busy}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
